// File: rtl/uart_mem_bridge_pkg.sv
// Shared definitions for the serial-to-memory bridge: frame command and
// response codes, the controller state encoding and a byte-select helper
// used when returning read data over the serial link.
package uart_mem_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        MEM  = 3'd3,
        RESP = 3'd4
    } state_t;

    // Little-endian byte lane select of a 32-bit word.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: host debug/loader bus initiator.
// Parses 'W' (addr + data) and 'R' (addr) frames from a byte receiver, runs one
// word access on a valid/ready memory bus and answers over a byte transmitter
// (ACK for writes, four little-endian data bytes for reads, NAK for unknown
// commands or a bus timeout).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_dout, rx_full, rx_re    receive byte, byte present, consume pulse
//   tx_din, tx_empty, tx_we    transmit byte, transmitter free, load pulse
//   mem_valid, mem_ready       bus request / completion
//   mem_addr, mem_wdata        word address (bits 1:0 zero), write data
//   mem_wstrb, mem_rdata       byte strobes (F write, 0 read), read data
//   cpu_halt                   high while a command is in flight
module uart_mem_bridge
    import uart_mem_bridge_pkg::*;
#(
    parameter int MEM_TIMEOUT   = 1024,
    parameter int FRAME_TIMEOUT = 52080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_dout,
    input  logic        rx_full,
    output logic        rx_re,
    output logic [7:0]  tx_din,
    input  logic        tx_empty,
    output logic        tx_we,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        cpu_halt
);

    localparam logic [15:0] MEM_LAST   = 16'(MEM_TIMEOUT - 1);
    localparam logic [15:0] FRAME_LAST = 16'(FRAME_TIMEOUT - 1);

    state_t      state_r;
    state_t      state_n_s;
    logic        rx_re_r;
    logic        tx_we_r;
    logic [7:0]  tx_din_r;
    logic        mem_valid_r;
    logic [3:0]  wstrb_r;
    logic        cpu_halt_r;
    logic [31:0] addr_r;
    logic [31:0] data_r;
    logic [31:0] rdata_r;
    logic [1:0]  cnt_r;
    logic [15:0] to_cnt_r;
    logic        is_write_r;
    logic        nak_r;

    logic        rx_take_s;
    logic        tx_take_s;
    logic        cmd_known_s;
    logic        frame_to_s;
    logic        mem_done_s;
    logic        mem_to_s;
    logic        resp_single_s;
    logic        last_tx_s;
    logic [7:0]  resp_byte_s;

    // The registered rx_re/tx_we double as the one-cycle guard: a byte is never
    // taken in the cycle its consume/load pulse is still visible.
    assign rx_take_s     = rx_full && !rx_re_r &&
                           ((state_r == IDLE) || (state_r == ADDR) || (state_r == DATA));
    assign tx_take_s     = (state_r == RESP) && tx_empty && !tx_we_r;
    assign cmd_known_s   = (rx_dout == CMD_WRITE) || (rx_dout == CMD_READ);
    assign frame_to_s    = ((state_r == ADDR) || (state_r == DATA)) && !rx_take_s &&
                           (to_cnt_r == FRAME_LAST);
    assign mem_done_s    = (state_r == MEM) && mem_valid_r && mem_ready;
    assign mem_to_s      = (state_r == MEM) && mem_valid_r && !mem_ready &&
                           (to_cnt_r == MEM_LAST);
    assign resp_single_s = nak_r || is_write_r;
    assign last_tx_s     = tx_take_s && (resp_single_s || (cnt_r == 2'd3));
    assign resp_byte_s   = nak_r      ? RSP_NAK :
                           is_write_r ? RSP_ACK : word_byte(rdata_r, cnt_r);

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state decode: command byte, 4 address bytes, 4 data bytes (write only),
    // bus access, response.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (rx_take_s) begin
                    if (cmd_known_s) begin
                        state_n_s = ADDR;
                    end else begin
                        state_n_s = RESP;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            ADDR: begin
                if (rx_take_s && (cnt_r == 2'd3)) begin
                    state_n_s = is_write_r ? DATA : MEM;
                end else if (frame_to_s) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = ADDR;
                end
            end
            DATA: begin
                if (rx_take_s && (cnt_r == 2'd3)) begin
                    state_n_s = MEM;
                end else if (frame_to_s) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = DATA;
                end
            end
            MEM: begin
                if (mem_done_s || mem_to_s) begin
                    state_n_s = RESP;
                end else begin
                    state_n_s = MEM;
                end
            end
            RESP: begin
                if (last_tx_s) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = RESP;
                end
            end
            default: state_n_s = IDLE;
        endcase
    end

    // Byte handshake pulses, frame capture shift registers and the byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_re_r    <= 1'b0;
            tx_we_r    <= 1'b0;
            tx_din_r   <= 8'h00;
            addr_r     <= 32'h0000_0000;
            data_r     <= 32'h0000_0000;
            cnt_r      <= 2'd0;
            is_write_r <= 1'b0;
        end else begin
            rx_re_r <= rx_take_s;
            tx_we_r <= tx_take_s;
            if (rx_take_s) begin
                if (state_r == IDLE) begin
                    is_write_r <= (rx_dout == CMD_WRITE);
                    cnt_r      <= 2'd0;
                end else if (state_r == ADDR) begin
                    // First address byte loses its low two bits so the bus address is word aligned.
                    addr_r <= {((cnt_r == 2'd0) ? (rx_dout & 8'hFC) : rx_dout), addr_r[31:8]};
                    cnt_r  <= cnt_r + 2'd1;
                end else begin
                    data_r <= {rx_dout, data_r[31:8]};
                    cnt_r  <= cnt_r + 2'd1;
                end
            end else if (tx_take_s) begin
                tx_din_r <= resp_byte_s;
                cnt_r    <= cnt_r + 2'd1;
            end else if (frame_to_s) begin
                cnt_r <= 2'd0;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Response selector: NAK for an unknown command or a bus timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nak_r <= 1'b0;
        end else if (rx_take_s && (state_r == IDLE)) begin
            nak_r <= !cmd_known_s;
        end else if (mem_to_s) begin
            nak_r <= 1'b1;
        end else begin
            nak_r <= nak_r;
        end
    end

    // Bus request: raised on entry to MEM, dropped on completion or timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_r <= 1'b0;
            wstrb_r     <= 4'h0;
            rdata_r     <= 32'h0000_0000;
        end else if ((state_r != MEM) && (state_n_s == MEM)) begin
            mem_valid_r <= 1'b1;
            wstrb_r     <= is_write_r ? 4'hF : 4'h0;
        end else if (mem_done_s) begin
            mem_valid_r <= 1'b0;
            wstrb_r     <= 4'h0;
            rdata_r     <= mem_rdata;
        end else if (mem_to_s) begin
            mem_valid_r <= 1'b0;
            wstrb_r     <= 4'h0;
        end else begin
            mem_valid_r <= mem_valid_r;
        end
    end

    // Shared timeout counter: inter-byte gap in ADDR/DATA, wait for ready in MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= 16'd0;
        end else if ((state_n_s != state_r) || rx_take_s) begin
            to_cnt_r <= 16'd0;
        end else if ((state_r == ADDR) || (state_r == DATA) || ((state_r == MEM) && mem_valid_r)) begin
            to_cnt_r <= to_cnt_r + 16'd1;
        end else begin
            to_cnt_r <= 16'd0;
        end
    end

    // Halt request: set the cycle after the command byte's consume pulse, cleared
    // the cycle after the final response byte's load pulse or on a frame abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_halt_r <= 1'b0;
        end else if (frame_to_s) begin
            cpu_halt_r <= 1'b0;
        end else if (tx_we_r && (state_r == IDLE)) begin
            cpu_halt_r <= 1'b0;
        end else if (rx_re_r && (state_r != IDLE)) begin
            cpu_halt_r <= 1'b1;
        end else begin
            cpu_halt_r <= cpu_halt_r;
        end
    end

    assign rx_re     = rx_re_r;
    assign tx_we     = tx_we_r;
    assign tx_din    = tx_din_r;
    assign mem_valid = mem_valid_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = data_r;
    assign mem_wstrb = wstrb_r;
    assign cpu_halt  = cpu_halt_r;

endmodule
